mii_tx_arbiter: RTL and testbench
=================================

# mii_tx_arbiter

Shares the single MII transmit nibble port between two frame reporters, for example the partial-data UDP reporter and a status/ARP reporter. Each reporter raises a request when it has a frame ready. The arbiter grants one reporter at a time in round-robin order, muxes the granted nibble stream to the PHY, and enforces the Ethernet inter-frame gap. It also guards the port with start and length watchdogs and keeps per-source frame counters.

## Interface
- START_TO, 64: cycles allowed from grant to the reporter's first tx_en.
- MAX_NIBBLES, 3072: maximum tx_en-high cycles per frame before a forced abort.
- IFG_NIBBLES, 24: idle cycles required between frames (96 bit times).
- clock  in  1  nibble clock (MII TX_CLK domain).
- sclr  in  1  reset, synchronous, active-high.
- req0, req1  in  1  reporter has a frame ready (level).
- ena0, ena1  out  1  grant; drives the reporter's ena input.
- txd0, txd1  in  4  reporter nibble data.
- txen0, txen1  in  1  reporter tx_en.
- mii_txd  out  4  PHY nibble data, registered.
- mii_tx_en  out  1  PHY tx_en, registered.
- busy  out  1  high in any state other than IDLE.
- frames0, frames1  out  16  completed-frame counters; wrap at 0xFFFF.
- err_start, err_len  out  1  sticky watchdog flags; cleared only by sclr.

## Operation
- States: IDLE, GRANT, SEND, GAP.
- IDLE:
  - Nothing requesting: stay.
  - Exactly one req high: select that source.
  - Both req high: select the source not equal to last_grant; last_grant resets to 1, so source 0 wins first.
  - Go to GRANT and record the selection in last_grant.
- GRANT:
  - ena of the selected source is high; the other ena is low.
  - Selected txen high: go to SEND. ena drops on the same edge.
  - START_TO cycles elapse without txen: set err_start and go to GAP. No frame is counted.
- SEND:
  - mii_txd/mii_tx_en follow the selected txd/txen.
  - The unselected source's txd/txen are ignored at all times.
  - Selected txen falls: increment that source's frames counter and go to GAP.
  - txen high for MAX_NIBBLES cycles: force mii_tx_en low from the next cycle, set err_len, go to GAP. No frame is counted.
- GAP:
  - Count IFG_NIBBLES cycles with mii_tx_en low.
  - Leave for IDLE only once the count is done and the selected txen is low. After an aborted frame the reporter may still be driving; its data is discarded.
- Any req or txen edge outside the granted slot has no effect.
- sclr mid-frame:
  - Next edge: state IDLE, mii_tx_en 0, mii_txd 0, ena0/ena1 0.
  - Counters cleared, error flags cleared, last_grant 1, watchdog and gap counters cleared.
- Reset values of every output: ena0 0, ena1 0, mii_txd 0, mii_tx_en 0, busy 0, frames0 0, frames1 0, err_start 0, err_len 0.

## Timing
- Grant latency: req seen high in IDLE at edge n gives ena high after edge n+1.
- Data path: one register stage. Reporter nibble at edge k appears on mii_txd/mii_tx_en after edge k+1, so preamble and CRC alignment are unchanged.
- Mux select is fixed from GRANT entry until IDLE; it never changes mid-frame.
- Gap: first gap cycle is the first cycle with mii_tx_en low. The earliest next ena is IFG_NIBBLES+1 cycles after that.
- Counter widths:
  - Start watchdog: 7 bits, sized for START_TO.
  - Length watchdog: 12 bits, sized for MAX_NIBBLES.
  - Gap counter: 5 bits, sized for IFG_NIBBLES.
  - All saturate; none wrap.
- frames counters update on the edge on which SEND exits to GAP.

## Structure
- Shared package holds:
  - the state enum (IDLE/GRANT/SEND/GAP);
  - the IFG_NIBBLES default (24);
  - the MII nibble width (4).
- Single module; no sub-module needed. Source mux, watchdog and gap counter live in one always block with the FSM.

## Test plan
- req0 only, reporter drives 2428 nibbles -> ena0 after 1 cycle; mii stream identical delayed 1 cycle; frames0=1; no errors.
- req0 and req1 simultaneous from reset -> source 0 served first, then source 1. Second ena rises ≥25 cycles after the first frame's mii_tx_en falls. frames0=1, frames1=1.
- req1 held continuously, req0 pulses each frame -> strict alternation 0,1,0,1; neither source starves.
- Granted reporter never raises txen -> err_start=1 after 64 cycles; ena drops; the other pending requester is granted after the gap.
- txen stuck high -> mii_tx_en forced low after 3072 cycles; err_len=1; frame not counted; IDLE only after txen falls and 24 gap cycles.
- sclr asserted mid-SEND -> next cycle mii_tx_en=0, ena=0, frames=0, flags=0; a fresh req is granted normally.

Source files
------------

// File: rtl/mii_tx_arbiter_pkg.sv
// rtl/mii_tx_arbiter_pkg.sv - shared types and constants for the MII transmit arbiter
package mii_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int IFG_NIBBLES_DEFAULT = 24;
  localparam int NIBBLE_W            = 4;

endpackage

// File: rtl/mii_tx_arbiter.sv
// rtl/mii_tx_arbiter.sv - round-robin owner of the MII TX nibble port for two reporters
// Registered data path, start/length watchdogs, inter-frame gap and per-source frame counters.
module mii_tx_arbiter
  import mii_tx_arbiter_pkg::*;
#(
  parameter int START_TO    = 64,
  parameter int MAX_NIBBLES = 3072,
  parameter int IFG_NIBBLES = IFG_NIBBLES_DEFAULT
) (
  input  logic                clock,
  input  logic                sclr,
  input  logic                req0,
  input  logic                req1,
  output logic                ena0,
  output logic                ena1,
  input  logic [NIBBLE_W-1:0] txd0,
  input  logic [NIBBLE_W-1:0] txd1,
  input  logic                txen0,
  input  logic                txen1,
  output logic [NIBBLE_W-1:0] mii_txd,
  output logic                mii_tx_en,
  output logic                busy,
  output logic [15:0]         frames0,
  output logic [15:0]         frames1,
  output logic                err_start,
  output logic                err_len
);

  localparam int SW = $clog2(START_TO + 1);
  localparam int LW = $clog2(MAX_NIBBLES + 1);
  localparam int GW = $clog2(IFG_NIBBLES + 1);

  localparam logic [SW-1:0] START_LAST = SW'(START_TO - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_NIBBLES);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IFG_NIBBLES - 1);

  arb_state_e          state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic [SW-1:0]       start_q, start_d;
  logic [LW-1:0]       len_q, len_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NIBBLE_W-1:0] txd_q, txd_d;
  logic                txen_q, txen_d;
  logic [15:0]         frames0_q, frames0_d;
  logic [15:0]         frames1_q, frames1_d;
  logic                err_start_q, err_start_d;
  logic                err_len_q, err_len_d;

  logic [NIBBLE_W-1:0] sel_txd;
  logic                sel_txen;
  logic                pick;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    start_d     = start_q;
    len_d       = len_q;
    gap_d       = gap_q;
    txd_d       = '0;
    txen_d      = 1'b0;
    frames0_d   = frames0_q;
    frames1_d   = frames1_q;
    err_start_d = err_start_q;
    err_len_d   = err_len_q;
    pick        = 1'b0;
    // select is frozen from GRANT entry to IDLE, so the other source never leaks through
    sel_txd     = sel_q ? txd1 : txd0;
    sel_txen    = sel_q ? txen1 : txen0;

    case (state_q)
      ST_IDLE: begin
        start_d = '0;
        len_d   = '0;
        gap_d   = '0;
        if (req0 || req1) begin
          pick    = (req0 && req1) ? ~last_q : req1;
          sel_d   = pick;
          last_d  = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (sel_txen) begin
          state_d = ST_SEND;
          txd_d   = sel_txd;
          txen_d  = 1'b1;
          len_d   = {{(LW-1){1'b0}}, 1'b1};
        end else if (start_q == START_LAST) begin
          err_start_d = 1'b1;
          gap_d       = '0;
          state_d     = ST_GAP;
        end else begin
          start_d = start_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (!sel_txen) begin
          if (sel_q) frames1_d = frames1_q + 16'd1;
          else       frames0_d = frames0_q + 16'd1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (len_q == LEN_MAX) begin
          err_len_d = 1'b1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          txd_d  = sel_txd;
          txen_d = 1'b1;
          len_d  = len_q + 1'b1;
        end
      end
      ST_GAP: begin
        // an aborted reporter may still be driving; hold here until it lets go
        if (gap_q == GAP_LAST) begin
          if (!sel_txen) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      start_q     <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      txd_q       <= '0;
      txen_q      <= 1'b0;
      frames0_q   <= '0;
      frames1_q   <= '0;
      err_start_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      start_q     <= start_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      frames0_q   <= frames0_d;
      frames1_q   <= frames1_d;
      err_start_q <= err_start_d;
      err_len_q   <= err_len_d;
    end
  end

  assign ena0      = (state_q == ST_GRANT) && !sel_q;
  assign ena1      = (state_q == ST_GRANT) &&  sel_q;
  assign mii_txd   = txd_q;
  assign mii_tx_en = txen_q;
  assign busy      = (state_q != ST_IDLE);
  assign frames0   = frames0_q;
  assign frames1   = frames1_q;
  assign err_start = err_start_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// tb/tb_mii_tx_arbiter.sv - directed self-checking bench for mii_tx_arbiter
module tb_mii_tx_arbiter;

  logic       clock = 1'b0;
  logic       sclr, req0, req1, txen0, txen1;
  logic [3:0] txd0, txd1;
  logic       ena0, ena1, mii_tx_en, busy, err_start, err_len;
  logic [3:0] mii_txd;
  logic [15:0] frames0, frames1;

  int n_total = 0;
  int n_bad   = 0;

  mii_tx_arbiter dut (
    .clock(clock), .sclr(sclr), .req0(req0), .req1(req1),
    .ena0(ena0), .ena1(ena1), .txd0(txd0), .txd1(txd1),
    .txen0(txen0), .txen1(txen1), .mii_txd(mii_txd), .mii_tx_en(mii_tx_en),
    .busy(busy), .frames0(frames0), .frames1(frames1),
    .err_start(err_start), .err_len(err_len)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit src, input logic en, input logic [3:0] d);
    if (src) begin txen1 = en; txd1 = d; end
    else     begin txen0 = en; txd0 = d; end
  endtask

  task automatic do_reset();
    sclr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    txen0 = 1'b0; txen1 = 1'b0; txd0 = 4'h0; txd1 = 4'h0;
    step(); step();
    sclr = 1'b0;
  endtask

  task automatic wait_grant(output int src, output int cycles);
    src = -1; cycles = 0;
    for (int i = 0; i < 200 && src < 0; i++) begin
      if (ena0)      src = 0;
      else if (ena1) src = 1;
      else begin step(); cycles++; end
    end
    if (src < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // drives n nibbles, compares the registered copy one edge later, then drops txen
  task automatic send_frame(input bit src, input int n, output int errs, output logic ena_after);
    logic [3:0] d;
    errs = 0;
    ena_after = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = 4'(i * 7 + 3);
      drive(src, 1'b1, d);
      step();
      if (i == 0) ena_after = src ? ena1 : ena0;
      if (mii_tx_en !== 1'b1 || mii_txd !== d) errs++;
    end
    drive(src, 1'b0, 4'h0);
    step();
  endtask

  int   errs, src, cyc, c;
  logic ea;

  initial begin
    // reset values
    do_reset();
    check("rst_ena0", 32'(ena0), 32'd0);
    check("rst_ena1", 32'(ena1), 32'd0);
    check("rst_txd", 32'(mii_txd), 32'd0);
    check("rst_txen", 32'(mii_tx_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames0", 32'(frames0), 32'd0);
    check("rst_frames1", 32'(frames1), 32'd0);
    check("rst_err_start", 32'(err_start), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);

    // single source, long frame, unselected source noisy
    req0 = 1'b1; txen1 = 1'b1; txd1 = 4'hF;
    step();
    check("t1_ena0", 32'(ena0), 32'd1);
    check("t1_ena1", 32'(ena1), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    send_frame(1'b0, 2428, errs, ea);
    check("t1_stream", 32'(errs), 32'd0);
    check("t1_ena_drop", 32'(ea), 32'd0);
    check("t1_txen_low", 32'(mii_tx_en), 32'd0);
    check("t1_frames0", 32'(frames0), 32'd1);
    check("t1_frames1", 32'(frames1), 32'd0);
    check("t1_errs", 32'({err_start, err_len}), 32'd0);
    wait_idle();
    txen1 = 1'b0; txd1 = 4'h0;

    // simultaneous requests from reset, gap to next grant
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t2_ena0", 32'(ena0), 32'd1);
    check("t2_ena1", 32'(ena1), 32'd0);
    req0 = 1'b0;
    send_frame(1'b0, 16, errs, ea);
    check("t2_stream0", 32'(errs), 32'd0);
    wait_grant(src, cyc);
    check("t2_src", 32'(src), 32'd1);
    check("t2_gap", 32'(cyc), 32'd25);
    req1 = 1'b0;
    send_frame(1'b1, 16, errs, ea);
    check("t2_stream1", 32'(errs), 32'd0);
    check("t2_frames0", 32'(frames0), 32'd1);
    check("t2_frames1", 32'(frames1), 32'd1);
    wait_idle();

    // alternation: req1 held, req0 re-pulsed after each frame
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_grant(src, cyc);
      check("t3_order", 32'(src), 32'(f % 2));
      if (src == 0) req0 = 1'b0;
      send_frame(src[0], 4, errs, ea);
      check("t3_stream", 32'(errs), 32'd0);
      req0 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    check("t3_frames0", 32'(frames0), 32'd2);
    check("t3_frames1", 32'(frames1), 32'd2);

    // start watchdog, other requester served after the gap
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("t4_ena0", 32'(ena0), 32'd1);
    req0 = 1'b0;
    c = 0;
    while (ena0 && c < 200) begin step(); c++; end
    check("t4_start_to", 32'(c), 32'd64);
    check("t4_err_start", 32'(err_start), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_frames0", 32'(frames0), 32'd0);
    wait_grant(src, cyc);
    check("t4_src", 32'(src), 32'd1);
    check("t4_gap", 32'(cyc), 32'd25);
    req1 = 1'b0;
    send_frame(1'b1, 10, errs, ea);
    check("t4_frames1", 32'(frames1), 32'd1);
    check("t4_err_len", 32'(err_len), 32'd0);
    wait_idle();

    // sclr mid-frame clears everything, then a fresh request works
    req0 = 1'b1;
    wait_grant(src, cyc);
    check("t6_src", 32'(src), 32'd0);
    req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 4'hA); step(); end
    check("t6_pre_txen", 32'(mii_tx_en), 32'd1);
    sclr = 1'b1;
    step();
    check("t6_txen", 32'(mii_tx_en), 32'd0);
    check("t6_txd", 32'(mii_txd), 32'd0);
    check("t6_ena", 32'({ena0, ena1}), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_frames1", 32'(frames1), 32'd0);
    check("t6_err_start", 32'(err_start), 32'd0);
    sclr = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    req0 = 1'b1;
    step();
    check("t6_regrant", 32'(ena0), 32'd1);
    req0 = 1'b0;
    send_frame(1'b0, 6, errs, ea);
    check("t6_stream", 32'(errs), 32'd0);
    check("t6_frames0", 32'(frames0), 32'd1);
    wait_idle();

    // txen stuck high: length abort
    do_reset();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    drive(1'b0, 1'b1, 4'h3);
    c = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (mii_tx_en) c++;
      else break;
    end
    check("t5_len", 32'(c), 32'd3072);
    check("t5_err_len", 32'(err_len), 32'd1);
    check("t5_frames0", 32'(frames0), 32'd0);
    repeat (40) step();
    check("t5_hold_busy", 32'(busy), 32'd1);
    check("t5_hold_txen", 32'(mii_tx_en), 32'd0);
    drive(1'b0, 1'b0, 4'h0);
    step();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_frames_end", 32'(frames0), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
